// File: rtl/pc_plus4.sv
// Fall-through next-PC adder for the single-cycle RV32 core, with wrap/misalignment
// status and a registered debug copy plus sticky error flags.
module pc_plus4 #(
  parameter int WIDTH = 32,
  parameter int INC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fromPC,
  output logic [WIDTH-1:0] NextoPC,
  output logic             wrap,
  output logic             misaligned,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] pc_q,
  output logic             wrap_sticky,
  output logic             misalign_sticky,
  output logic [7:0]       wrap_count
);

  // INC is a power of two >= 4, so the low ALIGN_W bits of the PC must be zero.
  localparam int ALIGN_W = $clog2(INC);

  logic [WIDTH:0] sumExt;

  function automatic logic [7:0] satInc(input logic [7:0] cnt);
    satInc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Stage 0: combinational adder and status, independent of clock and reset
  always_comb begin
    sumExt     = {1'b0, fromPC} + (WIDTH + 1)'(INC);
    NextoPC    = sumExt[WIDTH-1:0];
    wrap       = sumExt[WIDTH];
    misaligned = |fromPC[ALIGN_W-1:0];
  end

  // Stage 1: debug/trace registers; clear wins over a coincident set or count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= '0;
      wrap_sticky     <= 1'b0;
      misalign_sticky <= 1'b0;
      wrap_count      <= 8'd0;
    end else begin
      pc_q <= NextoPC;
      if (sticky_clr) begin
        wrap_sticky     <= 1'b0;
        misalign_sticky <= 1'b0;
        wrap_count      <= 8'd0;
      end else begin
        wrap_sticky     <= wrap_sticky | wrap;
        misalign_sticky <= misalign_sticky | misaligned;
        if (wrap) wrap_count <= satInc(wrap_count);
      end
    end
  end

endmodule

// File: tb/tb_pc_plus4.sv
// Directed + randomized bench for pc_plus4 against an arithmetic reference model.
module tb_pc_plus4;

  localparam int INC = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] fromPC;
  logic [31:0] NextoPC;
  logic        wrap;
  logic        misaligned;
  logic        sticky_clr;
  logic [31:0] pc_q;
  logic        wrap_sticky;
  logic        misalign_sticky;
  logic [7:0]  wrap_count;

  int vectors;
  int miscompares;

  // reference model state
  logic [31:0] mPc;
  logic        mWs;
  logic        mMs;
  int          mCnt;

  pc_plus4 #(.WIDTH(32), .INC(INC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fromPC(fromPC),
    .NextoPC(NextoPC),
    .wrap(wrap),
    .misaligned(misaligned),
    .sticky_clr(sticky_clr),
    .pc_q(pc_q),
    .wrap_sticky(wrap_sticky),
    .misalign_sticky(misalign_sticky),
    .wrap_count(wrap_count)
  );

  function automatic logic [63:0] fullSum(input logic [31:0] pc);
    fullSum = {32'd0, pc} + 64'(INC);
  endfunction

  function automatic logic [31:0] refNext(input logic [31:0] pc);
    logic [63:0] s;
    s = fullSum(pc) % 64'h1_0000_0000;
    refNext = s[31:0];
  endfunction

  function automatic logic refWrap(input logic [31:0] pc);
    refWrap = (fullSum(pc) > 64'h0000_0000_FFFF_FFFF);
  endfunction

  function automatic logic refMis(input logic [31:0] pc);
    refMis = ((pc % INC) != 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkComb(input string tag);
    chk({tag, ".NextoPC"}, NextoPC, refNext(fromPC));
    chk({tag, ".wrap"}, 32'(wrap), 32'(refWrap(fromPC)));
    chk({tag, ".misaligned"}, 32'(misaligned), 32'(refMis(fromPC)));
  endtask

  task automatic checkRegs(input string tag);
    chk({tag, ".pc_q"}, pc_q, mPc);
    chk({tag, ".wrap_sticky"}, 32'(wrap_sticky), 32'(mWs));
    chk({tag, ".misalign_sticky"}, 32'(misalign_sticky), 32'(mMs));
    chk({tag, ".wrap_count"}, 32'(wrap_count), 32'(mCnt));
  endtask

  task automatic modelReset();
    mPc  = '0;
    mWs  = 1'b0;
    mMs  = 1'b0;
    mCnt = 0;
  endtask

  // One full clock period: model absorbs pre-edge inputs, registers sampled 1 time unit after the edge.
  task automatic tick(input string tag);
    if (rst_n) begin
      mPc = refNext(fromPC);
      if (sticky_clr) begin
        mWs  = 1'b0;
        mMs  = 1'b0;
        mCnt = 0;
      end else begin
        mWs = mWs | refWrap(fromPC);
        mMs = mMs | refMis(fromPC);
        if (refWrap(fromPC)) mCnt = (mCnt >= 255) ? 255 : mCnt + 1;
      end
    end else begin
      modelReset();
    end
    #5 clk = 1'b1;
    #1 checkRegs(tag);
    #4 clk = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    modelReset();
    clk        = 1'b0;
    rst_n      = 1'b0;
    sticky_clr = 1'b0;
    fromPC     = 32'h0;

    // clock idle, reset asserted: adder still works, registers are clear
    #3;
    checkComb("idleReset");
    checkRegs("idleReset");

    rst_n = 1'b1;
    #2;
    fromPC = 32'h4;
    #1 checkComb("pc4");
    tick("pc4");

    fromPC = 32'hFFFF_FFFC;
    #1 checkComb("wrapTop");
    tick("wrapTop");

    fromPC = 32'h6;
    #1 checkComb("mis6");
    tick("mis6");
    fromPC = 32'h8;
    #1 checkComb("pc8");
    tick("misHold");
    sticky_clr = 1'b1;
    tick("clrPulse");
    sticky_clr = 1'b0;
    tick("afterClr");

    // saturate the wrap counter
    fromPC = 32'hFFFF_FFFC;
    for (int i = 0; i < 300; i++) tick("wrapSat");
    chk("wrapSatFinal", 32'(wrap_count), 32'd255);
    sticky_clr = 1'b1;
    #1 checkComb("clrVsWrap");
    tick("clrVsWrap");
    sticky_clr = 1'b0;

    // randomized traffic, biased toward the top of the address space and odd PCs
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: fromPC = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1: fromPC = $urandom & 32'hFFFF_FFFC;
        default: fromPC = $urandom;
      endcase
      sticky_clr = ($urandom_range(0, 9) == 0);
      #1 checkComb("rand");
      tick("rand");
    end
    sticky_clr = 1'b0;

    // build nonzero state then drop reset between edges
    fromPC = 32'hFFFF_FFFF;
    #1 checkComb("preAsync");
    tick("preAsync");
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkRegs("asyncReset");
    checkComb("asyncReset");
    tick("heldReset");
    rst_n = 1'b1;
    fromPC = 32'h0000_1000;
    #1 checkComb("resume");
    tick("resume");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_plus4.md
Name: pc_plus4

Overview:
- Sequential-PC increment unit for the single-cycle RV32 CPU; sits between the PC register and the next-PC mux.
- Combinationally produces fromPC + 4, which is the fall-through next-PC.
- Also provides wrap and misalignment status.
- Provides a registered copy of the result and sticky error flags for debug/trace. These are clocked by the CPU clock and cleared by the asynchronous active-low reset.

Parameters:
- WIDTH, 32, address width in bits.
- INC, 4, increment added to fromPC (instruction size in bytes). It must be a power of two, at least 4.

Ports:
- clk, input, 1, CPU clock. All registers update on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- fromPC, input, WIDTH, current PC value.
- NextoPC, output, WIDTH, fromPC + INC modulo 2^WIDTH. This output is combinational.
- wrap, output, 1, combinational. It is 1 when fromPC + INC overflows WIDTH bits.
- misaligned, output, 1, combinational. It is 1 when fromPC[log2(INC)-1:0] != 0.
- sticky_clr, input, 1, synchronous clear of the sticky flags.
- pc_q, output, WIDTH, NextoPC registered on each rising clk.
- wrap_sticky, output, 1, set when wrap=1 at a rising edge. It holds until sticky_clr or reset.
- misalign_sticky, output, 1, set when misaligned=1 at a rising edge. It holds until sticky_clr or reset.
- wrap_count, output, 8, number of rising edges at which wrap=1. It saturates at 255.

Behaviour:
Combinational path:
- NextoPC, wrap and misaligned are pure combinational functions of fromPC only.
- They must not depend on clk, rst_n or any register, and must be valid even when clk is idle or unconnected and while rst_n is low.
- NextoPC = (fromPC + INC) truncated to WIDTH bits. Plain unsigned add with no saturation. The carry out drives wrap.
- Example: fromPC=32'hFFFFFFFC gives NextoPC=32'h00000000 and wrap=1.
- misaligned does not alter NextoPC. The add is performed on the full value regardless of alignment.

Reset:
- While rst_n is low: pc_q=0, wrap_sticky=0, misalign_sticky=0, wrap_count=0.
- Reset is asserted asynchronously, with no clock needed.
- Registers resume capturing at the first rising clk after rst_n rises.
- If reset is asserted mid-operation, all registered state clears immediately. Combinational outputs are unaffected.

Registered path, per rising clk edge when rst_n=1:
- pc_q <= NextoPC, giving one-cycle latency.
- If sticky_clr=1: both sticky flags go to 0 and wrap_count goes to 0. Clear takes priority over a simultaneous set or increment.
- Otherwise:
  - wrap_sticky <= wrap_sticky | wrap.
  - misalign_sticky <= misalign_sticky | misaligned.
  - wrap_count increments by 1 when wrap=1 and wrap_count<255, and holds at 255.

There is no handshake: the unit is always ready and has no state machine.

Test Plan:
- fromPC=0, clk idle and rst_n=0 -> after settle, NextoPC=4, wrap=0, misaligned=0. This confirms independence from clock and reset.
- fromPC=4 -> NextoPC=8, wrap=0. After one rising clk with rst_n=1, pc_q=8.
- fromPC=32'hFFFFFFFC -> NextoPC=0, wrap=1. After one clk, wrap_sticky=1, wrap_count=1 and pc_q=0.
- fromPC=32'h00000006 -> NextoPC=32'h0000000A, misaligned=1. After one clk, misalign_sticky=1. Then with fromPC=8 the flag stays 1. Pulsing sticky_clr for one clk takes it to 0.
- Hold fromPC=32'hFFFFFFFC for 300 clks -> wrap_count saturates at 255. Asserting sticky_clr and wrap=1 on the same edge -> wrap_count=0 and wrap_sticky=0.
- Drop rst_n between clock edges with nonzero registered state -> pc_q, sticky flags and wrap_count are 0 immediately, while NextoPC still equals fromPC+4.
